// File: rtl/bin_to_bcd4.sv
// Sequential double-dabble converter: BIN_W-bit unsigned binary to four BCD digits.
// Define BIN_TO_BCD4_SATURATE_EN to clamp overflowing results to 9999.
module bin_to_bcd4 #(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic [3:0]       c,
  output logic [3:0]       d
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e           r_state;
  logic [BIN_W-1:0] r_bin;
  logic [19:0]      r_bcd;
  logic [4:0]       r_cnt;

  logic [18:0]      w_adj;
  logic             w_ovf;
  logic [15:0]      w_digits;

  // The ten-thousands nibble never exceeds 3 before the final shift, so it needs no
  // add-3 correction and its top bit is never shifted out.
  always_comb begin
    w_adj = r_bcd[18:0];
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_ovf = (r_bcd[19:16] != 4'd0);

`ifdef BIN_TO_BCD4_SATURATE_EN
  assign w_digits = w_ovf ? 16'h9999 : r_bcd[15:0];
`else
  assign w_digits = r_bcd[15:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      a        <= 4'd0;
      b        <= 4'd0;
      c        <= 4'd0;
      d        <= 4'd0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= StConv;
          end else begin
            r_state <= StIdle;
          end
        end
        StConv: begin
          if (r_cnt == 5'(BIN_W)) begin
            // All iterations complete: publish digits and flag together.
            {d, c, b, a} <= w_digits;
            overflow     <= w_ovf;
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= StDone;
          end else begin
            r_bcd <= {w_adj, r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd4.md
BIN_TO_BCD4 -- requirements
Module: bin_to_bcd4

Interface
REQ-001 SHALL provide parameter BIN_W, default 14, binary input width; legal range 14..16.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to convert bin; sampled on posedge clk.
REQ-005 SHALL provide port bin  input  BIN_W  unsigned binary value; sampled only on the accepting edge.
REQ-006 SHALL provide port busy  output  1  conversion in progress; start ignored while high.
REQ-007 SHALL provide port done  output  1  one-cycle pulse; digits updated this cycle.
REQ-008 SHALL provide port overflow  output  1  last accepted bin exceeded 9999.
REQ-009 SHALL provide ports a, b, c, d  output  4 each  BCD ones, tens, hundreds, thousands; these connect directly to the four-digit display driver's a..d inputs, with a at select position 0.

Function
REQ-010 SHALL implement FSM states IDLE, CONV, DONE; DONE occupies exactly one cycle.
REQ-011 SHALL, in IDLE with start=1 at edge k, latch bin, clear the internal BCD shift register, zero the iteration counter, and enter CONV; busy=1 from edge k.
REQ-012 SHALL, in CONV, perform one double-dabble iteration per cycle: first add 3 to every internal BCD nibble >=5, then shift left one bit, taking the MSB of the latched bin.
REQ-013 SHALL carry five internal BCD nibbles so any BIN_W<=16 value converts exactly; the fifth nibble (ten-thousands) is used only for overflow handling.
REQ-014 SHALL leave CONV for DONE after exactly BIN_W iterations; at edge k+BIN_W+1, update a..d and overflow together, set done=1, set busy=0.
REQ-015 SHALL return from DONE to IDLE on the next edge; done=0 there.
REQ-016 SHALL hold a..d and overflow stable between done pulses; no intermediate values visible.
REQ-017 SHALL ignore start while busy=1; no relatch, no restart, no latency change.
REQ-018 SHALL accept start in the cycle done=1, since busy=0 then and the accepting edge moves the FSM DONE->CONV; back-to-back conversions every BIN_W+2 cycles.
REQ-019 SHALL set overflow=1 when the latched value >9999, else 0.
REQ-020 SHALL give conversion latency from accepting edge to done-high edge of exactly BIN_W+1 cycles, independent of value.

Reset
REQ-021 SHALL, on reset=1 at any edge, force state IDLE, busy=0, done=0, overflow=0, a=b=c=d=0, counter=0.
REQ-022 SHALL, on reset during CONV, abort the conversion; no done pulse follows, and the partial result is discarded.
REQ-023 SHALL give reset priority over start on the same edge; start is not accepted.

Configuration
REQ-024 SHALL gate overflow saturation with macro BIN_TO_BCD4_SATURATE_EN.
REQ-025 SHALL, with BIN_TO_BCD4_SATURATE_EN defined, output d,c,b,a=9,9,9,9 when overflow=1.
REQ-026 SHALL, without BIN_TO_BCD4_SATURATE_EN, output the low four BCD digits (value mod 10000) when overflow=1; overflow is still flagged.
REQ-027 SHALL leave latency, handshake and non-overflow results unaffected by the macro.

Verification
REQ-028 SHALL cover: BIN_W=14, bin=0, start at edge k -> done high at edge k+15, d..a=0,0,0,0, overflow=0, busy low at k+15.
REQ-029 SHALL cover: bin=1234 -> d..a=1,2,3,4; bin=9999 -> 9,9,9,9, overflow=0.
REQ-030 SHALL cover: bin=16383 -> overflow=1; macro defined d..a=9,9,9,9; macro undefined d..a=6,3,8,3.
REQ-031 SHALL cover: start=1 held through a conversion of 42 with bin changed to 777 at k+3 -> result 0,0,4,2 at k+15, then 777 accepted on the done cycle with done at k+31.
REQ-032 SHALL cover: reset at k+7 mid-conversion of 5555 -> no done pulse, outputs 0, busy=0; a fresh start after reset converts normally.
REQ-033 SHALL cover: reset and start asserted on the same edge -> busy stays 0 and no done pulse occurs.
